// File: rtl/mul16_seq_ctrl.sv
// Sequential 16x16 multiplier built from one shared 8x8 magnitude multiplier.
// Operands go through sign-magnitude, four partial products are accumulated, then the sign is reapplied.
module mul16_seq_ctrl #(
    parameter int USE_SIGN = 1,
    parameter int RES_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        negative,
    output logic        overflow
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PP0  = 3'd1;
    localparam logic [2:0] S_PP1  = 3'd2;
    localparam logic [2:0] S_PP2  = 3'd3;
    localparam logic [2:0] S_PP3  = 3'd4;
    localparam logic [2:0] S_FIX  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]  state;
    logic [15:0] mag_a;
    logic [15:0] mag_b;
    logic        sign;
    logic [31:0] acc;

    logic        accept;
    logic [15:0] abs_a;
    logic [15:0] abs_b;
    logic        op_sign;
    logic [7:0]  unit_a;
    logic [7:0]  unit_b;
    logic [15:0] unit_p;
    logic [31:0] addend;
    logic [31:0] fix_product;
    logic        fix_negative;
    logic        fix_overflow;
    logic [32-RES_W:0] hi_signed;
    logic [31-RES_W:0] hi_unsigned;

    assign in_ready = rst_n && (state == S_IDLE);
    assign accept   = in_valid && in_ready && !clear;

    // 16-bit two's complement negate maps -32768 onto 0x8000, which is its magnitude.
    always_comb begin
        if (USE_SIGN != 0) begin
            abs_a   = op_a[15] ? (~op_a + 16'd1) : op_a;
            abs_b   = op_b[15] ? (~op_b + 16'd1) : op_b;
            op_sign = op_a[15] ^ op_b[15];
        end else begin
            abs_a   = op_a;
            abs_b   = op_b;
            op_sign = 1'b0;
        end
    end

    always_comb begin
        unit_a = mag_a[7:0];
        unit_b = mag_b[7:0];
        case (state)
            S_PP1: begin
                unit_a = mag_a[7:0];
                unit_b = mag_b[15:8];
            end
            S_PP2: begin
                unit_a = mag_a[15:8];
                unit_b = mag_b[7:0];
            end
            S_PP3: begin
                unit_a = mag_a[15:8];
                unit_b = mag_b[15:8];
            end
            default: begin
                unit_a = mag_a[7:0];
                unit_b = mag_b[7:0];
            end
        endcase
    end

    // The single shared 8x8 unsigned multiplier.
    assign unit_p = {8'd0, unit_a} * {8'd0, unit_b};

    always_comb begin
        addend = '0;
        case (state)
            S_PP0:        addend = {16'd0, unit_p};
            S_PP1, S_PP2: addend = {8'd0, unit_p, 8'd0};
            S_PP3:        addend = {unit_p, 16'd0};
            default:      addend = '0;
        endcase
    end

    assign fix_negative = sign && (acc != '0);
    assign fix_product  = fix_negative ? (~acc + 32'd1) : acc;
    assign hi_signed    = fix_product[31:RES_W-1];
    assign hi_unsigned  = fix_product[31:RES_W];

    // Signed fit means every bit from RES_W-1 upward is a copy of the sign bit.
    always_comb begin
        if (USE_SIGN != 0) begin
            fix_overflow = !((hi_signed == '0) || (hi_signed == '1));
        end else begin
            fix_overflow = (hi_unsigned != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mag_a     <= '0;
            mag_b     <= '0;
            sign      <= 1'b0;
            acc       <= '0;
            product   <= '0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        sign  <= op_sign;
                        acc   <= '0;
                        state <= S_PP0;
                    end
                end
                S_PP0, S_PP1, S_PP2, S_PP3: begin
                    acc   <= acc + addend;
                    state <= state + 3'd1;
                end
                S_FIX: begin
                    product   <= fix_product;
                    negative  <= fix_negative;
                    overflow  <= fix_overflow;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
